stream_upsizer: RTL
===================

Name: stream_upsizer

Overview:
- Downstream neighbour of the 8-bit elastic buffer. Consumes its byte stream (valid/ready plus a last flag) and packs RATIO consecutive bytes into one wide word.
- The wide word carries a per-byte keep mask and last flag, and feeds the wide datapath.
- Sustains full bandwidth: one byte accepted per cycle with no bubbles at word boundaries. A word is flushed early on last.

Parameters:
- IN_WIDTH, 8, width of one input beat (byte lane width).
- RATIO, 4, input beats per output word; legal range 2..16.
- OUT_WIDTH, IN_WIDTH*RATIO, derived; not overridable.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- upstream_vld  input  1  input beat valid.
- upstream_rdy  output  1  input beat ready.
- upstream_data  input  IN_WIDTH  input beat payload.
- upstream_last  input  1  beat is final of packet.
- downstream_vld  output  1  output word valid (registered).
- downstream_rdy  input  1  output word ready.
- downstream_data  output  OUT_WIDTH  packed word; lane 0 = bits [IN_WIDTH-1:0] = first byte.
- downstream_keep  output  RATIO  lane valid mask, contiguous from bit 0.
- downstream_last  output  1  word ends a packet.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (rst high at clock edge):
  - downstream_vld=0, downstream_data=0, downstream_keep=0, downstream_last=0.
  - Accumulator count=0, accumulator data/keep=0, closed flag=0.
  - upstream_rdy is held 0 while rst is high.
  - Reset mid-packet discards any partial word and any unaccepted output word, with no flush.
- Storage: accumulator (RATIO-1 lanes, count acc_cnt in 0..RATIO-1, flag acc_closed) plus one output register.
- Definitions:
  - push = upstream_vld & upstream_rdy.
  - pop = downstream_vld & downstream_rdy.
  - out_free = !downstream_vld | downstream_rdy.
- upstream_rdy = !rst & !acc_closed & ((acc_cnt != RATIO-1) | out_free).
  - Combinational from state and downstream_rdy only.
  - Never depends on upstream_vld, upstream_data or upstream_last.
- On push, the byte is written to lane acc_cnt.
  - Word completes if acc_cnt==RATIO-1 or upstream_last==1.
  - Not complete: acc_cnt <= acc_cnt+1.
  - Complete and out_free:
    - Output register loads the accumulator lanes merged with the incoming byte, same edge.
    - keep = lanes 0..acc_cnt set.
    - last = upstream_last.
    - Unused lanes = 0.
    - Accumulator clears.
    - Latency: last byte accepted at edge N, word visible downstream at N.
  - Complete but !out_free: only possible with upstream_last and acc_cnt<RATIO-1.
    - Byte stored, acc_cnt <= acc_cnt+1, acc_closed <= 1, upstream_rdy drops.
- acc_closed & out_free: closed word (keep = lanes 0..acc_cnt-1, last=1) moves to the output register. Accumulator clears and acc_closed <= 0. Upstream is ready again next cycle.
- Output register:
  - Holds data/keep/last stable while downstream_vld & !downstream_rdy.
  - Pop with no new load: downstream_vld <= 0; data/keep/last hold their values.
  - Pop and load on the same edge: the new word replaces the old and downstream_vld stays 1.
- Throughput: back-to-back bytes with downstream_rdy=1 give one word every RATIO cycles with no stall cycles.
- Stall: acc_cnt==RATIO-1 and output occupied and not popped → upstream_rdy=0 until pop.
- Single-byte packet (last on lane 0): keep=0b0001, last=1.
- last on lane RATIO-1: keep all ones, last=1.
- Bytes after last start a new word at lane 0.
- Empty: downstream_vld=0 whenever no complete word is held. Partial words never emit without last.

Test Plan:
- Reset then 8 bytes 0x01..0x08, no last, downstream_rdy=1 → words 0x04030201 then 0x08070605, keep=0xF, last=0, upstream_rdy=1 every cycle, 2 output words in 8 cycles.
- Bytes 0xAA,0xBB with last on 0xBB, downstream_rdy=1 → one word data=0x0000BBAA, keep=0x3, last=1, in the same cycle as 0xBB accepted.
- downstream_rdy=0, send 4 bytes then 0x11(last) → first word held stable; after the 0x11 push the accumulator is closed and upstream_rdy=0. Raise rdy → pop 1st word. Next cycle output=0x00000011, keep=0x1, last=1, then upstream_rdy returns 1.
- downstream_rdy=0 with output full, send 3 bytes → upstream_rdy=1 for 3 cycles then 0 (acc_cnt=3). Toggle rdy → pop and load on same edge, downstream_vld never drops.
- Random vld/rdy, 1000 bytes, random last ~1/7 → scoreboard byte order, keep contiguity, last placement. No loss or duplication, no data change while vld&!rdy.
- Assert rst mid-word (acc_cnt=2) and with output valid → next cycle downstream_vld=0, keep=0, upstream_rdy=0 during rst, 1 after. Next word starts at lane 0.

Source files
------------

// File: rtl/stream_upsizer_if.sv
// Byte-in / word-out stream bundle for stream_upsizer.
// master drives the byte stream and accepts words; slave is the upsizer itself.
interface stream_upsizer_if #(
  parameter int unsigned IN_WIDTH = 8,
  parameter int unsigned RATIO    = 4
);
  localparam int unsigned OUT_WIDTH = IN_WIDTH * RATIO;

  logic                 upstream_vld;
  logic                 upstream_rdy;
  logic [IN_WIDTH-1:0]  upstream_data;
  logic                 upstream_last;

  logic                 downstream_vld;
  logic                 downstream_rdy;
  logic [OUT_WIDTH-1:0] downstream_data;
  logic [RATIO-1:0]     downstream_keep;
  logic                 downstream_last;

  modport master (
    output upstream_vld, upstream_data, upstream_last, downstream_rdy,
    input  upstream_rdy, downstream_vld, downstream_data, downstream_keep, downstream_last
  );

  modport slave (
    input  upstream_vld, upstream_data, upstream_last, downstream_rdy,
    output upstream_rdy, downstream_vld, downstream_data, downstream_keep, downstream_last
  );
endinterface

// File: rtl/stream_upsizer.sv
// Packs RATIO consecutive input beats into one wide word with keep mask and last flag.
// Full-rate at word boundaries; a packet's last beat flushes a partial word early.
module stream_upsizer #(
  parameter int unsigned IN_WIDTH = 8,
  parameter int unsigned RATIO    = 4
) (
  input logic             clk,
  input logic             rst,
  stream_upsizer_if.slave bus
);
  localparam int unsigned OUT_WIDTH = IN_WIDTH * RATIO;
  localparam int unsigned CntW      = $clog2(RATIO);
  localparam logic [CntW-1:0] LastLane = CntW'(RATIO - 1);

  logic [OUT_WIDTH-1:0] acc_data_q, acc_data_d;
  logic [CntW-1:0]      acc_cnt_q, acc_cnt_d;
  logic                 acc_closed_q, acc_closed_d;

  logic                 out_vld_q, out_vld_d;
  logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
  logic [RATIO-1:0]     out_keep_q, out_keep_d;
  logic                 out_last_q, out_last_d;

  logic                 out_free;
  logic                 push;
  logic                 complete;
  logic [OUT_WIDTH-1:0] merged;
  logic [RATIO-1:0]     keep_incl;
  logic [RATIO-1:0]     keep_excl;

  assign out_free = !out_vld_q | bus.downstream_rdy;
  assign bus.upstream_rdy = !rst & !acc_closed_q & ((acc_cnt_q != LastLane) | out_free);
  assign push     = bus.upstream_vld & bus.upstream_rdy;
  assign complete = (acc_cnt_q == LastLane) | bus.upstream_last;

  assign bus.downstream_vld  = out_vld_q;
  assign bus.downstream_data = out_data_q;
  assign bus.downstream_keep = out_keep_q;
  assign bus.downstream_last = out_last_q;

  // Lanes above acc_cnt are always zero in the accumulator, so merging keeps unused lanes clear.
  always_comb begin
    merged = acc_data_q;
    merged[32'(acc_cnt_q) * IN_WIDTH +: IN_WIDTH] = bus.upstream_data;
    for (int unsigned i = 0; i < RATIO; i++) begin
      keep_incl[i] = (i <= 32'(acc_cnt_q));
      keep_excl[i] = (i < 32'(acc_cnt_q));
    end
  end

  always_comb begin
    acc_data_d   = acc_data_q;
    acc_cnt_d    = acc_cnt_q;
    acc_closed_d = acc_closed_q;
    out_vld_d    = out_vld_q;
    out_data_d   = out_data_q;
    out_keep_d   = out_keep_q;
    out_last_d   = out_last_q;

    if (bus.downstream_rdy) begin
      out_vld_d = 1'b0;
    end

    if (acc_closed_q) begin
      // Closed word already holds its last beat; it only waits for the output slot.
      if (out_free) begin
        out_vld_d    = 1'b1;
        out_data_d   = acc_data_q;
        out_keep_d   = keep_excl;
        out_last_d   = 1'b1;
        acc_data_d   = '0;
        acc_cnt_d    = '0;
        acc_closed_d = 1'b0;
      end
    end else if (push) begin
      if (!complete) begin
        acc_data_d = merged;
        acc_cnt_d  = acc_cnt_q + CntW'(1);
      end else if (out_free) begin
        out_vld_d  = 1'b1;
        out_data_d = merged;
        out_keep_d = keep_incl;
        out_last_d = bus.upstream_last;
        acc_data_d = '0;
        acc_cnt_d  = '0;
      end else begin
        acc_data_d   = merged;
        acc_cnt_d    = acc_cnt_q + CntW'(1);
        acc_closed_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_data_q   <= '0;
      acc_cnt_q    <= '0;
      acc_closed_q <= 1'b0;
      out_vld_q    <= 1'b0;
      out_data_q   <= '0;
      out_keep_q   <= '0;
      out_last_q   <= 1'b0;
    end else begin
      acc_data_q   <= acc_data_d;
      acc_cnt_q    <= acc_cnt_d;
      acc_closed_q <= acc_closed_d;
      out_vld_q    <= out_vld_d;
      out_data_q   <= out_data_d;
      out_keep_q   <= out_keep_d;
      out_last_q   <= out_last_d;
    end
  end
endmodule
